// File: rtl/plot_capture_sequencer_pkg.sv
// Shared constants and the plot sequencer state type for the ADC trace capture path.
package plot_capture_sequencer_pkg;

  localparam int ADC_BITS     = 12;
  localparam int CHANNELS     = 2;
  localparam int PLOT_W       = 518;
  localparam int PLOT_H       = 159;

  localparam int bitsPlotResH = $clog2(PLOT_W);
  localparam int bitsPlotResV = $clog2(PLOT_H);
  localparam int bitsChannel  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  // Dividend is sample * PLOT_H, which needs ADC_BITS + 8 bits; one quotient bit per step.
  localparam int DIV_STEPS    = ADC_BITS + 8;

  typedef enum logic [2:0] {IDLE, LOAD, DIV, WRITE, NEXT} plotState_t;

endpackage

// File: rtl/plot_capture_sequencer_scale_div.sv
// Sequential unsigned restoring divider that scales one sample to plot height,
// with the quotient clamped so full scale stays inside the plot window.
module plot_scale_div #(
  parameter int DIVIDEND_W = 20,
  parameter int DIVISOR_W  = 12,
  parameter int OUT_W      = 8,
  parameter int SAT_MAX    = 158
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic                  done,
  output logic [OUT_W-1:0]      quotient_sat
);

  localparam int CNT_W = $clog2(DIVIDEND_W + 1);

  logic [DIVISOR_W-1:0]  rem;
  logic [DIVISOR_W-1:0]  divReg;
  logic [DIVIDEND_W-1:0] quotient;
  logic [CNT_W-1:0]      cnt;
  logic                  running;

  logic [DIVISOR_W-1:0]  stepRemIn;
  logic [DIVIDEND_W-1:0] stepQIn;
  logic [DIVISOR_W-1:0]  stepDiv;
  logic [DIVISOR_W:0]    trial;
  logic [DIVISOR_W-1:0]  stepRemOut;
  logic [DIVIDEND_W-1:0] stepQOut;

  // The first step is taken on the start edge itself so the whole divide spans DIVIDEND_W edges.
  always_comb begin
    stepRemIn  = start ? '0 : rem;
    stepQIn    = start ? dividend : quotient;
    stepDiv    = start ? divisor : divReg;
    trial      = {stepRemIn, stepQIn[DIVIDEND_W-1]};
    stepRemOut = trial[DIVISOR_W-1:0];
    stepQOut   = {stepQIn[DIVIDEND_W-2:0], 1'b0};
    if (trial >= {1'b0, stepDiv}) begin
      stepRemOut  = DIVISOR_W'(trial - {1'b0, stepDiv});
      stepQOut[0] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem      <= '0;
      divReg   <= '0;
      quotient <= '0;
      cnt      <= '0;
      running  <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        rem      <= stepRemOut;
        quotient <= stepQOut;
        divReg   <= divisor;
        cnt      <= CNT_W'(DIVIDEND_W - 1);
        running  <= 1'b1;
      end else if (running) begin
        rem      <= stepRemOut;
        quotient <= stepQOut;
        cnt      <= cnt - 1'b1;
        if (cnt == CNT_W'(1)) begin
          running <= 1'b0;
          done    <= 1'b1;
        end
      end
    end
  end

  assign quotient_sat = (quotient > DIVIDEND_W'(SAT_MAX)) ? OUT_W'(SAT_MAX) : quotient[OUT_W-1:0];

endmodule

// File: rtl/plot_capture_sequencer.sv
// Captures one ADC sample per channel on each synchronised ready strobe, scales it to
// plot height and writes it into the shared trace RAM at the current sweep column.
module plot_capture_sequencer
  import plot_capture_sequencer_pkg::*;
(
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [CHANNELS-1:0][ADC_BITS-1:0]  adc,
  input  logic                               ready,
  input  logic                               freeze,
  input  logic                               clr_overrun,
  output logic                               wr_en,
  output logic [bitsChannel-1:0]             wr_ch,
  output logic [bitsPlotResH-1:0]            wr_addr,
  output logic [bitsPlotResV-1:0]            wr_data,
  output logic                               busy,
  output logic                               overrun,
  output logic                               sweep_done
);

  plotState_t                        state;
  logic                              s1, s2, s3;
  logic                              start;
  logic [CHANNELS-1:0][ADC_BITS-1:0] sample;
  logic [bitsChannel-1:0]            ch;
  logic [bitsPlotResH-1:0]           idx;
  logic [DIV_STEPS-1:0]              dividend;
  logic                              divStart;
  logic                              divDone;
  logic [bitsPlotResV-1:0]           divSat;

  // ready comes from the ADC clock domain; only its synchronised rising edge is used.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= ready;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign start    = s2 & ~s3;
  assign divStart = (state == LOAD);
  assign dividend = DIV_STEPS'(sample[ch]) * DIV_STEPS'(PLOT_H);

  plot_scale_div #(
    .DIVIDEND_W (DIV_STEPS),
    .DIVISOR_W  (ADC_BITS),
    .OUT_W      (bitsPlotResV),
    .SAT_MAX    (PLOT_H - 1)
  ) u_div (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (divStart),
    .dividend     (dividend),
    .divisor      ({ADC_BITS{1'b1}}),
    .done         (divDone),
    .quotient_sat (divSat)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      idx        <= '0;
      ch         <= '0;
      sample     <= '0;
      wr_en      <= 1'b0;
      wr_ch      <= '0;
      wr_addr    <= '0;
      wr_data    <= '0;
      busy       <= 1'b0;
      overrun    <= 1'b0;
      sweep_done <= 1'b0;
    end else begin
      wr_en      <= 1'b0;
      sweep_done <= 1'b0;

      // A dropped strobe outranks a clear arriving in the same cycle.
      if (start && (state != IDLE) && !freeze) begin
        overrun <= 1'b1;
      end else if (clr_overrun) begin
        overrun <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (start && !freeze) begin
            sample <= adc;
            ch     <= '0;
            busy   <= 1'b1;
            state  <= LOAD;
          end
        end
        LOAD: state <= DIV;
        DIV: begin
          if (divDone) begin
            wr_en   <= 1'b1;
            wr_ch   <= ch;
            wr_addr <= idx;
            wr_data <= divSat;
            state   <= WRITE;
          end
        end
        WRITE: begin
          if (ch < bitsChannel'(CHANNELS - 1)) begin
            ch    <= ch + 1'b1;
            state <= LOAD;
          end else begin
            state <= NEXT;
          end
        end
        NEXT: begin
          if (idx == bitsPlotResH'(PLOT_W - 1)) begin
            idx        <= '0;
            sweep_done <= 1'b1;
          end else begin
            idx <= idx + 1'b1;
          end
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_plot_capture_sequencer.sv
// Scoreboard bench: stimulus queues expected plot RAM writes, a monitor pops them on wr_en.
module tb_plot_capture_sequencer;
  import plot_capture_sequencer_pkg::*;

  typedef struct {
    int ch;
    int addr;
    int data;
    int cyc;
  } expWrite_t;

  logic                              clk = 1'b0;
  logic                              rst_n = 1'b1;
  logic                              ready = 1'b0;
  logic                              freeze = 1'b0;
  logic                              clr_overrun = 1'b0;
  logic [CHANNELS-1:0][ADC_BITS-1:0] adc = '0;
  logic                              wr_en;
  logic [bitsChannel-1:0]            wr_ch;
  logic [bitsPlotResH-1:0]           wr_addr;
  logic [bitsPlotResV-1:0]           wr_data;
  logic                              busy;
  logic                              overrun;
  logic                              sweep_done;

  int        cyc = 0;
  int        checks = 0;
  int        errors = 0;
  int        expAddr = 0;
  int        writeCount = 0;
  int        sweepCount = 0;
  int        lastSweepCyc = -1;
  expWrite_t expQ[$];
  expWrite_t monE;

  plot_capture_sequencer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .adc         (adc),
    .ready       (ready),
    .freeze      (freeze),
    .clr_overrun (clr_overrun),
    .wr_en       (wr_en),
    .wr_ch       (wr_ch),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .busy        (busy),
    .overrun     (overrun),
    .sweep_done  (sweep_done)
  );

  always #50 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  function automatic int scaleModel(input int s);
    int q;
    q = (s * PLOT_H) / 4095;
    return (q > PLOT_H - 1) ? PLOT_H - 1 : q;
  endfunction

  task automatic waitCycle(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  // Raises ready just after an edge, so start is seen two edges later.
  task automatic applyStimulus(input int a0, input int a1, input bit expectWrite,
                               input int exp0, input int exp1, output int startCyc);
    adc[0] = ADC_BITS'(a0);
    adc[1] = ADC_BITS'(a1);
    @(posedge clk);
    #1 ready = 1'b1;
    startCyc = cyc + 2;
    if (expectWrite) begin
      expQ.push_back('{0, expAddr, exp0, startCyc + 22});
      expQ.push_back('{1, expAddr, exp1, startCyc + 44});
      expAddr = (expAddr == PLOT_W - 1) ? 0 : expAddr + 1;
    end
    repeat (3) @(posedge clk);
    #1 ready = 1'b0;
  endtask

  always @(negedge clk) begin
    if (rst_n && sweep_done) begin
      sweepCount++;
      lastSweepCyc = cyc;
    end
    if (rst_n && wr_en) begin
      writeCount++;
      if (expQ.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_write: got ch %0d addr %0d data %0d, expected no write (cycle %0d)",
                 wr_ch, wr_addr, wr_data, cyc);
      end else begin
        monE = expQ.pop_front();
        checkOutput("wr_ch", int'(wr_ch), monE.ch);
        checkOutput("wr_addr", int'(wr_addr), monE.addr);
        checkOutput("wr_data", int'(wr_data), monE.data);
        checkOutput("wr_cycle", cyc, monE.cyc);
      end
    end
  end

  initial begin
    int s;
    int m;
    int wc;
    int base;
    int a0;
    int a1;

    #5 rst_n = 1'b0;
    #10;
    checkOutput("rst_wr_en", int'(wr_en), 0);
    checkOutput("rst_wr_ch", int'(wr_ch), 0);
    checkOutput("rst_wr_addr", int'(wr_addr), 0);
    checkOutput("rst_wr_data", int'(wr_data), 0);
    checkOutput("rst_busy", int'(busy), 0);
    checkOutput("rst_overrun", int'(overrun), 0);
    checkOutput("rst_sweep_done", int'(sweep_done), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Basic capture with latency and occupancy
    applyStimulus(2048, 1000, 1'b1, 79, 38, s);
    waitCycle(s + 1);
    checkOutput("busy_start", int'(busy), 1);
    waitCycle(s + 45);
    checkOutput("busy_last", int'(busy), 1);
    waitCycle(s + 46);
    checkOutput("busy_drop", int'(busy), 0);
    waitCycle(s + 50);

    // Full scale saturates, zero stays zero
    applyStimulus(4095, 0, 1'b1, 158, 0, s);
    waitCycle(s + 50);

    // Strobe while busy is dropped and flagged
    wc = writeCount;
    applyStimulus(100, 200, 1'b1, 3, 7, s);
    waitCycle(s + 8);
    applyStimulus(1, 1, 1'b0, 0, 0, m);
    waitCycle(s + 50);
    checkOutput("overrun_set", int'(overrun), 1);
    checkOutput("overrun_writes", writeCount - wc, 2);
    checkOutput("overrun_queue", expQ.size(), 0);
    @(posedge clk);
    #1 clr_overrun = 1'b1;
    @(posedge clk);
    #1 clr_overrun = 1'b0;
    checkOutput("overrun_clr", int'(overrun), 0);

    // Clear coinciding with a new overrun event
    applyStimulus(4095, 4095, 1'b1, 158, 158, s);
    waitCycle(s + 10);
    @(posedge clk);
    #1 ready = 1'b1;
    m = cyc;
    while (cyc < m + 2) begin
      @(posedge clk);
      #1;
    end
    clr_overrun = 1'b1;
    @(posedge clk);
    #1 clr_overrun = 1'b0;
    ready = 1'b0;
    checkOutput("overrun_set_wins", int'(overrun), 1);
    waitCycle(s + 50);
    @(posedge clk);
    #1 clr_overrun = 1'b1;
    @(posedge clk);
    #1 clr_overrun = 1'b0;
    checkOutput("overrun_clr2", int'(overrun), 0);

    // Frozen strobes are ignored entirely
    freeze = 1'b1;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(500 + i, 600, 1'b0, 0, 0, s);
      waitCycle(s + 3);
      checkOutput("freeze_busy", int'(busy), 0);
      waitCycle(s + 20);
    end
    checkOutput("freeze_overrun", int'(overrun), 0);
    freeze = 1'b0;

    // Freeze raised mid-sequence lets it finish
    applyStimulus(1234, 2345, 1'b1, 47, 91, s);
    waitCycle(s + 10);
    freeze = 1'b1;
    waitCycle(s + 50);
    checkOutput("freeze_mid_queue", expQ.size(), 0);
    freeze = 1'b0;

    // Reset during the ch1 divide aborts the second write
    applyStimulus(3000, 500, 1'b1, 116, 19, s);
    waitCycle(s + 30);
    rst_n = 1'b0;
    #1;
    checkOutput("abort_wr_en", int'(wr_en), 0);
    checkOutput("abort_wr_data", int'(wr_data), 0);
    checkOutput("abort_wr_addr", int'(wr_addr), 0);
    checkOutput("abort_busy", int'(busy), 0);
    checkOutput("abort_pending", expQ.size(), 1);
    expQ.delete();
    expAddr = 0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    waitCycle(s + 60);
    applyStimulus(2048, 1000, 1'b1, 79, 38, s);
    waitCycle(s + 50);

    // Full sweep wraps the column index once
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    expAddr = 0;
    base = sweepCount;
    for (int i = 0; i < PLOT_W; i++) begin
      a0 = (i * 37) % 4096;
      a1 = 4095 - ((i * 13) % 4096);
      applyStimulus(a0, a1, 1'b1, scaleModel(a0), scaleModel(a1), s);
      waitCycle(s + 48);
      if (i == PLOT_W - 2) checkOutput("sweep_early", sweepCount - base, 0);
    end
    checkOutput("sweep_count", sweepCount - base, 1);
    checkOutput("sweep_cycle", lastSweepCyc, s + 46);
    applyStimulus(4000, 100, 1'b1, 155, 3, s);
    waitCycle(s + 50);

    checkOutput("final_queue", expQ.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
